clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Parametrised, lock-qualified clock-enable generator for the readout firmware. It monitors the DCM `LOCKED` flag and sequences the DCM reset with a timeout and retry. It produces `CHANNELS` independent strobe and square-wave outputs from `BUS_CLK`, each with a programmable divide ratio and phase, so new slow clocks (SPI, ADC encode, trigger) need no additional DCM outputs or BUFGs. It sits next to the clock generator and feeds all slow-clock consumers.

## Interface
- `CHANNELS`, 4, number of output channels (1..16)
- `DIV_WIDTH`, 8, width of per-channel divide and phase fields
- `RST_DLY`, 4, cycles `DCM_RST` is held per reset attempt (>=1)
- `LOCK_FILTER`, 16, consecutive synchronised-high `LOCKED_IN` cycles required before running (>=1)
- `LOCK_TIMEOUT`, 1024, cycles in WAIT_LOCK before retrying the DCM reset
- `BUS_CLK`  in  1  sole clock
- `BUS_RST_N`  in  1  reset, asynchronous, active-low
- `LOCKED_IN`  in  1  DCM lock flag, asynchronous to `BUS_CLK`
- `DIV`  in  CHANNELS*DIV_WIDTH  per channel: period = DIV+1 cycles
- `PHASE`  in  CHANNELS*DIV_WIDTH  per channel: strobe offset within the period
- `ALIGN`  in  1  synchronous pulse that restarts all channel counters
- `DCM_RST`  out  1  reset to the DCM, active-high
- `READY`  out  1  channels running
- `CE_OUT`  out  CHANNELS  one-cycle strobe per period
- `CLK_OUT`  out  CHANNELS  square wave, high in the first half of the period
- `LOCK_LOST_CNT`  out  8  saturating count of lock losses while running

## Operation
- `LOCKED_IN` passes through a 2-FF synchroniser giving `lock_s`. All decisions use `lock_s`.
- **States and transitions:**
  - RST_DCM: `DCM_RST`=1. After `RST_DLY` cycles, go to WAIT_LOCK.
  - WAIT_LOCK: a filter counter increments while `lock_s`=1 and clears when `lock_s`=0.
    - When the counter reaches `LOCK_FILTER`, go to RUN.
    - After `LOCK_TIMEOUT` cycles in this state, go to RST_DCM.
  - RUN: `READY`=1. When `lock_s`=0, go to RST_DCM and increment `LOCK_LOST_CNT`, saturating at 255.
- **Channel i** holds a counter `cnt` over 0..D, where D is the active divide value.
  - `CE_OUT[i]`=1 for one cycle when `cnt`==Peff, where Peff = min(PHASE, D).
  - `CLK_OUT[i]`=1 while `cnt` < ceil((D+1)/2). With D=0, `CLK_OUT` is constantly 1 and `CE_OUT` fires every cycle.
- **Shadow registers:** `DIV` and `PHASE` are copied into the active registers only at wrap (`cnt`==D), at RUN entry, or on `ALIGN`. Changes made mid-period never produce a runt period.
- Outside RUN, `CE_OUT`=0, `CLK_OUT`=0, and the counters are held at 0.
- `ALIGN` is ignored outside RUN. In RUN it loads all counters to 0 and copies the shadow registers.

## Timing
- **Reset values** (`BUS_RST_N`=0): state RST_DCM, `DCM_RST`=1, `READY`=0, `CE_OUT`=0, `CLK_OUT`=0, `LOCK_LOST_CNT`=0, all counters 0.
- **Release from reset:** `DCM_RST` deasserts after edge `RST_DLY`.
- **Lock latency:** 2 synchroniser cycles plus `LOCK_FILTER` cycles from the `LOCKED_IN` rise to `READY`=1.
- **Outputs are registered.** If the counters are 0 after edge k (RUN entry or `ALIGN`), then:
  - `CE_OUT[i]` is high for the cycle after edge k+Peff+1;
  - `CLK_OUT[i]` rises after edge k+1.
- **Lock loss:** when `lock_s` falls at edge k, all of the following take effect together after edge k+1: `READY`=0, `DCM_RST`=1, `CE_OUT`=`CLK_OUT`=0, and the counter increments.
- **Simultaneous events:** if `ALIGN` arrives in the same cycle as a lock drop, lock loss wins. If `ALIGN` coincides with a wrap, the result is identical (`cnt`→0, shadow copied).
- **Glitch rejection:** a `lock_s` glitch in WAIT_LOCK restarts the filter but does not restart the timeout.

## Structure
- Shared package `clk_gen_pkg`: state encodings (RST_DCM, WAIT_LOCK, RUN), the 8-bit lock-loss counter width, and the Peff clamp helper function.
- Sub-module `clk_en_div`: one channel (shadow registers, counter, compare, registered `CE`/`CLK`), instantiated `CHANNELS` times by a generate loop.
- The top level contains the synchroniser, the state machine, the timers, and `LOCK_LOST_CNT`.

## Test plan
- **Reset:** `BUS_RST_N` low, `LOCKED_IN`=1 → `DCM_RST`=1. After release, `DCM_RST` stays 1 for 4 cycles, then `READY`=1 after 2+16 further cycles.
- **Divide and phase:** DIV=9, PHASE=3 on channel 0 and DIV=0 on channel 1, then `ALIGN`:
  - channel 0: `CE_OUT[0]` every 10 cycles, first at ALIGN+5; `CLK_OUT[0]` high 5 cycles, low 5 cycles;
  - channel 1: `CE_OUT[1]` constantly high.
- **Mid-period change:** DIV changed from 9 to 3 at `cnt`=2 → the current period completes at 10 cycles, the next is 4 cycles, with no extra strobe.
- **Lock loss:** `LOCKED_IN` dropped for 1 cycle in RUN → `READY` falls, outputs go to 0, `LOCK_LOST_CNT`=1, and the full RST_DCM/WAIT_LOCK sequence repeats. 300 drops → `LOCK_LOST_CNT` holds 255.
- **Timeout:** `LOCKED_IN` held at 0 → `DCM_RST` pulses for 4 cycles every 4+1024 cycles. `LOCKED_IN` toggling every 10 cycles never reaches RUN.
- **Clamp and precedence:** PHASE=7 with DIV=3 → `CE_OUT` at Peff=3. `ALIGN` in the same cycle as a lock drop → lock-loss behaviour only.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared definitions for the lock-qualified clock-enable generator.
//   state_e      : sequencer states (DCM reset, waiting for lock, channels running)
//   LockLostW    : width of the saturating lock-loss counter
//   clamp_phase  : effective strobe phase, min(phase, div)
package clk_gen_pkg;

    typedef enum logic [1:0] {
        StRstDcm   = 2'd0,
        StWaitLock = 2'd1,
        StRun      = 2'd2
    } state_e;

    localparam int unsigned LockLostW = 8;

    // A phase beyond the period end would never match the counter, so pin it to the last count.
    function automatic int unsigned clamp_phase(input int unsigned phase, input int unsigned div);
        return (phase > div) ? div : phase;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: divide counter, active divide/phase registers and registered outputs.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : channel running this cycle and next (outputs enabled, counter advancing)
//   load_i        : restart counter at 0 and take div_i/phase_i (RUN entry or align)
//   div_i         : requested divide value, period = div_i + 1 cycles
//   phase_i       : requested strobe offset within the period
//   ce_o          : one-cycle strobe when the counter equals the effective phase
//   clk_o         : square wave, high for the first ceil((D+1)/2) counts
module clk_en_div
    import clk_gen_pkg::*;
#(
    parameter int unsigned DivWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                load_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic [DivWidth-1:0] phase_i,
    output logic                ce_o,
    output logic                clk_o
);

    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [DivWidth-1:0] peff_q, peff_d;
    logic                ce_q, ce_d;
    logic                clk_q, clk_d;
    logic                wrap;

    assign wrap = (cnt_q == div_q);

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        peff_d = peff_q;
        // New settings only take effect on a period boundary, so no runt period is produced.
        if (load_i || (en_i && wrap)) begin
            cnt_d  = '0;
            div_d  = div_i;
            peff_d = DivWidth'(clamp_phase(32'(phase_i), 32'(div_i)));
        end else if (en_i) begin
            cnt_d = cnt_q + DivWidth'(1);
        end else begin
            cnt_d = '0;
        end
        // Outputs are a registered view of the current count; ceil((D+1)/2) == D/2 + 1.
        ce_d  = en_i && (cnt_q == peff_q);
        clk_d = en_i && (cnt_q <= (div_q >> 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            div_q  <= '0;
            peff_q <= '0;
            ce_q   <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            peff_q <= peff_d;
            ce_q   <= ce_d;
            clk_q  <= clk_d;
        end
    end

    assign ce_o  = ce_q;
    assign clk_o = clk_q;

endmodule

// File: rtl/clk_en_gen.sv
// Lock-qualified clock-enable generator. Sequences the DCM reset with timeout/retry, qualifies
// LOCKED through a synchroniser and filter, and drives CHANNELS divided strobes/square waves.
//   BUS_CLK, BUS_RST_N : sole clock, asynchronous active-low reset
//   LOCKED_IN          : DCM lock flag (asynchronous)
//   DIV, PHASE         : per-channel divide (period DIV+1) and strobe phase, DIV_WIDTH each
//   ALIGN              : restart all channel counters (honoured only while running)
//   DCM_RST            : active-high DCM reset
//   READY              : channels running
//   CE_OUT, CLK_OUT    : per-channel strobe and square wave
//   LOCK_LOST_CNT      : saturating count of lock losses while running
module clk_en_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned DIV_WIDTH    = 8,
    parameter int unsigned RST_DLY      = 4,
    parameter int unsigned LOCK_FILTER  = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                          BUS_CLK,
    input  logic                          BUS_RST_N,
    input  logic                          LOCKED_IN,
    input  logic [CHANNELS*DIV_WIDTH-1:0] DIV,
    input  logic [CHANNELS*DIV_WIDTH-1:0] PHASE,
    input  logic                          ALIGN,
    output logic                          DCM_RST,
    output logic                          READY,
    output logic [CHANNELS-1:0]           CE_OUT,
    output logic [CHANNELS-1:0]           CLK_OUT,
    output logic [LockLostW-1:0]          LOCK_LOST_CNT
);

    localparam int unsigned TimerMax = (LOCK_TIMEOUT > RST_DLY) ? LOCK_TIMEOUT : RST_DLY;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam int unsigned FiltW    = $clog2(LOCK_FILTER + 1);

    state_e               state_q, state_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [FiltW-1:0]     filt_q, filt_d;
    logic [LockLostW-1:0] lost_q, lost_d;
    logic [1:0]           sync_q, sync_d;
    logic                 dcm_rst_q, ready_q;
    logic                 lock_s;
    logic                 ch_en, ch_load;

    assign lock_s = sync_q[1];

    // LOCKED from a DCM held in reset is meaningless; flush the synchroniser so the filter
    // only ever counts lock seen after the reset has been released.
    always_comb begin
        sync_d = {sync_q[0], LOCKED_IN};
        if (state_q == StRstDcm) begin
            sync_d = 2'b00;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TimerW'(1);
        filt_d  = '0;
        lost_d  = lost_q;
        unique case (state_q)
            StRstDcm: begin
                if (timer_q == TimerW'(RST_DLY - 1)) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end
            end
            StWaitLock: begin
                // A lock glitch restarts only the filter; the timeout keeps running.
                if (lock_s) begin
                    filt_d = filt_q + FiltW'(1);
                end
                if (lock_s && (filt_q == FiltW'(LOCK_FILTER - 1))) begin
                    state_d = StRun;
                    timer_d = '0;
                    filt_d  = '0;
                end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
                    state_d = StRstDcm;
                    timer_d = '0;
                    filt_d  = '0;
                end
            end
            StRun: begin
                timer_d = '0;
                if (!lock_s) begin
                    state_d = StRstDcm;
                    if (lost_q != '1) begin
                        lost_d = lost_q + LockLostW'(1);
                    end
                end
            end
            default: begin
                state_d = StRstDcm;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q   <= StRstDcm;
            timer_q   <= '0;
            filt_q    <= '0;
            lost_q    <= '0;
            sync_q    <= 2'b00;
            dcm_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            filt_q    <= filt_d;
            lost_q    <= lost_d;
            sync_q    <= sync_d;
            dcm_rst_q <= (state_d == StRstDcm);
            ready_q   <= (state_d == StRun);
        end
    end

    // Channels count only while running now and next cycle, so a lock drop (even with a
    // coincident ALIGN) zeroes the outputs on the same edge that READY falls.
    assign ch_en   = (state_q == StRun) && (state_d == StRun);
    assign ch_load = (state_d == StRun) && ((state_q != StRun) || ALIGN);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        clk_en_div #(
            .DivWidth(DIV_WIDTH)
        ) u_div (
            .clk_i  (BUS_CLK),
            .rst_ni (BUS_RST_N),
            .en_i   (ch_en),
            .load_i (ch_load),
            .div_i  (DIV[gi*DIV_WIDTH +: DIV_WIDTH]),
            .phase_i(PHASE[gi*DIV_WIDTH +: DIV_WIDTH]),
            .ce_o   (CE_OUT[gi]),
            .clk_o  (CLK_OUT[gi])
        );
    end

    assign DCM_RST       = dcm_rst_q;
    assign READY         = ready_q;
    assign LOCK_LOST_CNT = lost_q;

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;

    logic        bus_clk;
    logic        bus_rst_n;
    logic        locked_in;
    logic [31:0] div;
    logic [31:0] phase;
    logic        align;
    logic        dcm_rst;
    logic        ready;
    logic [3:0]  ce_out;
    logic [3:0]  clk_out;
    logic [7:0]  lock_lost_cnt;

    int checks;
    int failures;
    int exp_llc;

    clk_en_gen #(
        .CHANNELS    (4),
        .DIV_WIDTH   (8),
        .RST_DLY     (4),
        .LOCK_FILTER (16),
        .LOCK_TIMEOUT(1024)
    ) dut (
        .BUS_CLK      (bus_clk),
        .BUS_RST_N    (bus_rst_n),
        .LOCKED_IN    (locked_in),
        .DIV          (div),
        .PHASE        (phase),
        .ALIGN        (align),
        .DCM_RST      (dcm_rst),
        .READY        (ready),
        .CE_OUT       (ce_out),
        .CLK_OUT      (clk_out),
        .LOCK_LOST_CNT(lock_lost_cnt)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sample one time unit after the active edge; inputs are also driven here.
    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 1200; i++) begin
            if (ready === 1'b1) break;
            tick();
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready: READY=%b required 1 within 1200 cycles", ready);
        end
    endtask

    // One-cycle drop on LOCKED_IN; returns after the edge that first samples it low.
    task automatic drop_lock();
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
    endtask

    task automatic test_reset();
        bit exp_dcm, exp_rdy;
        repeat (3) tick();
        checks++;
        if (dcm_rst !== 1'b1 || ready !== 1'b0 || ce_out !== 4'h0 || clk_out !== 4'h0 ||
            lock_lost_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: dcm=%b ready=%b ce=%h clk=%h llc=%0d required 1 0 0 0 0",
                     dcm_rst, ready, ce_out, clk_out, lock_lost_cnt);
        end
        bus_rst_n = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            tick();
            exp_dcm = (n < 4);
            exp_rdy = (n >= 22);
            checks++;
            if (dcm_rst !== exp_dcm || ready !== exp_rdy) begin
                failures++;
                $display("FAIL reset_release edge %0d: dcm=%b ready=%b required %b %b",
                         n, dcm_rst, ready, exp_dcm, exp_rdy);
            end
        end
    endtask

    task automatic test_divide();
        int cnt;
        logic [1:0] exp_ce, exp_clk;
        div   = 32'h0000_0009;
        phase = 32'h0000_0003;
        align = 1'b1;
        tick();
        align = 1'b0;
        for (int m = 1; m <= 25; m++) begin
            tick();
            cnt     = (m - 1) % 10;
            exp_ce  = {1'b1, cnt == 3};
            exp_clk = {1'b1, cnt <= 4};
            checks++;
            if (ce_out[1:0] !== exp_ce || clk_out[1:0] !== exp_clk) begin
                failures++;
                $display("FAIL divide m=%0d: ce=%b clk=%b required %b %b",
                         m, ce_out[1:0], clk_out[1:0], exp_ce, exp_clk);
            end
        end
    endtask

    task automatic test_mid_change();
        int c, cnt, d;
        bit exp_ce, exp_clk;
        align = 1'b1;
        tick();
        align = 1'b0;
        for (int m = 1; m <= 24; m++) begin
            tick();
            c = m - 1;
            if (c < 10) begin
                cnt = c;
                d   = 9;
            end else begin
                cnt = (c - 10) % 4;
                d   = 3;
            end
            exp_ce  = (cnt == 3);
            exp_clk = (cnt <= d / 2);
            checks++;
            if (ce_out[0] !== exp_ce || clk_out[0] !== exp_clk) begin
                failures++;
                $display("FAIL mid_change m=%0d: ce0=%b clk0=%b required %b %b",
                         m, ce_out[0], clk_out[0], exp_ce, exp_clk);
            end
            if (m == 2) div[7:0] = 8'd3;
        end
    endtask

    task automatic test_clamp();
        int cnt;
        bit exp_ce, exp_clk;
        div[7:0]   = 8'd3;
        phase[7:0] = 8'd7;
        align = 1'b1;
        tick();
        align = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            tick();
            cnt     = (m - 1) % 4;
            exp_ce  = (cnt == 3);
            exp_clk = (cnt <= 1);
            checks++;
            if (ce_out[0] !== exp_ce || clk_out[0] !== exp_clk) begin
                failures++;
                $display("FAIL clamp m=%0d: ce0=%b clk0=%b required %b %b",
                         m, ce_out[0], clk_out[0], exp_ce, exp_clk);
            end
        end
    endtask

    task automatic test_lock_loss();
        bit exp_dcm, exp_rdy;
        logic [3:0] exp_ce, exp_clk;
        drop_lock();
        tick();
        checks++;
        if (ready !== 1'b1 || clk_out[1] !== 1'b1 || lock_lost_cnt !== 8'(exp_llc)) begin
            failures++;
            $display("FAIL loss_edge_k: ready=%b clk1=%b llc=%0d required 1 1 %0d",
                     ready, clk_out[1], lock_lost_cnt, exp_llc);
        end
        tick();
        exp_llc++;
        checks++;
        if (ready !== 1'b0 || dcm_rst !== 1'b1 || ce_out !== 4'h0 || clk_out !== 4'h0 ||
            lock_lost_cnt !== 8'(exp_llc)) begin
            failures++;
            $display("FAIL loss_edge_k1: ready=%b dcm=%b ce=%h clk=%h llc=%0d required 0 1 0 0 %0d",
                     ready, dcm_rst, ce_out, clk_out, lock_lost_cnt, exp_llc);
        end
        for (int n = 2; n <= 24; n++) begin
            tick();
            exp_dcm = (n <= 4);
            exp_rdy = (n >= 23);
            exp_ce  = (n >= 24) ? 4'hE : 4'h0;
            exp_clk = (n >= 24) ? 4'hF : 4'h0;
            checks++;
            if (dcm_rst !== exp_dcm || ready !== exp_rdy || ce_out !== exp_ce ||
                clk_out !== exp_clk) begin
                failures++;
                $display("FAIL relock n=%0d: dcm=%b ready=%b ce=%h clk=%h required %b %b %h %h",
                         n, dcm_rst, ready, ce_out, clk_out, exp_dcm, exp_rdy, exp_ce, exp_clk);
            end
        end
    endtask

    task automatic test_align_vs_loss();
        drop_lock();
        tick();
        align = 1'b1;
        tick();
        align = 1'b0;
        exp_llc++;
        checks++;
        if (ready !== 1'b0 || dcm_rst !== 1'b1 || ce_out !== 4'h0 || clk_out !== 4'h0 ||
            lock_lost_cnt !== 8'(exp_llc)) begin
            failures++;
            $display("FAIL align_vs_loss: ready=%b dcm=%b ce=%h clk=%h llc=%0d required 0 1 0 0 %0d",
                     ready, dcm_rst, ce_out, clk_out, lock_lost_cnt, exp_llc);
        end
        wait_ready();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 250; i++) begin
            drop_lock();
            repeat (3) tick();
            wait_ready();
        end
        exp_llc += 250;
        checks++;
        if (lock_lost_cnt !== 8'(exp_llc)) begin
            failures++;
            $display("FAIL llc_count: llc=%0d required %0d", lock_lost_cnt, exp_llc);
        end
        for (int i = 0; i < 50; i++) begin
            drop_lock();
            repeat (3) tick();
            wait_ready();
        end
        checks++;
        if (lock_lost_cnt !== 8'd255) begin
            failures++;
            $display("FAIL llc_saturate: llc=%0d required 255", lock_lost_cnt);
        end
    endtask

    task automatic test_timeout();
        bit exp_dcm;
        locked_in = 1'b0;
        tick();
        tick();
        for (int n = 1; n <= 2100; n++) begin
            tick();
            exp_dcm = (((n - 1) % 1028) < 4);
            checks++;
            if (dcm_rst !== exp_dcm || ready !== 1'b0) begin
                failures++;
                $display("FAIL timeout n=%0d: dcm=%b ready=%b required %b 0",
                         n, dcm_rst, ready, exp_dcm);
            end
        end
    endtask

    task automatic test_toggle();
        int  rises;
        logic prev;
        rises = 0;
        prev  = dcm_rst;
        for (int n = 0; n < 3000; n++) begin
            if (n % 10 == 0) locked_in = ~locked_in;
            tick();
            if (dcm_rst === 1'b1 && prev === 1'b0) rises++;
            prev = dcm_rst;
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL toggle n=%0d: ready=%b required 0", n, ready);
            end
        end
        checks++;
        if (rises < 2 || rises > 3) begin
            failures++;
            $display("FAIL toggle_retries: dcm_rst rises=%0d required 2..3", rises);
        end
        locked_in = 1'b1;
        wait_ready();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_llc   = 0;
        bus_rst_n = 1'b1;
        locked_in = 1'b1;
        div       = '0;
        phase     = '0;
        align     = 1'b0;
        #2;
        bus_rst_n = 1'b0;
        test_reset();
        test_divide();
        test_mid_change();
        test_clamp();
        test_lock_loss();
        test_align_vs_loss();
        test_saturate();
        test_timeout();
        test_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
